enemy_patrol: RTL and testbench

Parametrised patrolling-enemy sprite controller, the general successor to the single-instance enemy blocks. It spawns on request and walks a configurable horizontal patrol segment at a configurable speed. It spots the player through a directional, range-limited view cone, dies through a timed dying phase when hit, and produces per-pixel coverage plus a mirrored, animated sprite-ROM address for the colour mapper. One instance is used per enemy; instances differ only by parameters.

---
 rtl/enemy_pkg.sv | 31 +++
 rtl/enemy_patrol_if.sv | 33 +++
 rtl/frame_tick_sync.sv | 28 ++
 rtl/enemy_patrol.sv | 182 ++++++++++++++++++
 tb/tb_enemy_patrol.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/enemy_pkg.sv
// Shared types and helpers for the patrolling-enemy sprite blocks.
package enemy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PATROL = 3'd1,
        ST_ALERT  = 3'd2,
        ST_DYING  = 3'd3,
        ST_DEAD   = 3'd4
    } enemy_state_t;

    localparam logic FACE_LEFT  = 1'b0;
    localparam logic FACE_RIGHT = 1'b1;

    // Sprite ROM address: frames are stored back to back, rows of W pixels,
    // and a left-facing sprite reads each row mirrored.
    function automatic logic [31:0] sprite_addr(
        input logic [31:0] base,
        input logic [31:0] frame,
        input logic [31:0] w,
        input logic [31:0] h,
        input logic [31:0] row,
        input logic [31:0] col,
        input logic        face
    );
        logic [31:0] off;
        off = face ? col : (w - 32'd1 - col);
        return base + frame * w * h + row * w + off;
    endfunction

endpackage

// File: rtl/enemy_patrol_if.sv
// Signal bundle between the scene logic (master) and one enemy instance (slave).
// Protocol: no valid/ready pairs here. spawn is a one-cycle pulse sampled on
// every Clk edge; hit, camo, char_pos, char_w and DrawX/DrawY are levels.
// The enemy drives its outputs continuously; state and pos_x are debug taps.
interface enemy_patrol_if #(parameter int ADDR_W = 16);
    import enemy_pkg::*;

    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              spawn;
    logic [9:0]        char_pos;
    logic [9:0]        char_w;
    logic              hit;
    logic              camo;
    logic              is_enemy;
    logic [ADDR_W-1:0] enemy_addr;
    logic              enemy_alive;
    logic              detect;
    logic              facing;
    enemy_state_t      state;
    logic [9:0]        pos_x;

    modport master (
        output DrawX, DrawY, spawn, char_pos, char_w, hit, camo,
        input  is_enemy, enemy_addr, enemy_alive, detect, facing, state, pos_x
    );

    modport slave (
        input  DrawX, DrawY, spawn, char_pos, char_w, hit, camo,
        output is_enemy, enemy_addr, enemy_alive, detect, facing, state, pos_x
    );

endinterface

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and turns each
// rising edge into a single-cycle tick, registered so it follows the edge
// by three Clk cycles.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic s1, s2, s3;

    // Two-flop synchroniser, one history flop, registered rising-edge pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= frame_clk;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/enemy_patrol.sv
// One patrolling enemy: spawn, walk a horizontal segment, spot the player in
// a forward view cone, die through a blinking phase, and map the current
// pixel to a mirrored, animated sprite ROM address.
module enemy_patrol
    import enemy_pkg::*;
#(
    parameter logic [9:0]  X_MIN       = 10'd350,
    parameter logic [9:0]  X_MAX       = 10'd580,
    parameter logic [9:0]  X_START     = 10'd520,
    parameter logic [9:0]  Y_TOP       = 10'd358,
    parameter logic [9:0]  W           = 10'd60,
    parameter logic [9:0]  H           = 10'd54,
    parameter logic [9:0]  SPEED       = 10'd1,
    parameter logic [9:0]  VIEW_DIST   = 10'd200,
    parameter int          N_WALK      = 2,
    parameter int          ANIM_DIV    = 8,
    parameter int          DEATH_TICKS = 30,
    parameter logic [15:0] ROM_BASE    = 16'd34372,
    parameter int          ADDR_W      = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           frame_clk,
    enemy_patrol_if.slave  bus
);

    localparam logic [7:0] ANIM_LAST  = 8'(ANIM_DIV - 1);
    localparam logic [1:0] FRAME_LAST = 2'(N_WALK - 1);
    localparam logic [7:0] DEATH_LOAD = 8'(DEATH_TICKS - 1);

    enemy_state_t state, state_n;
    logic [9:0]   x, x_n, x_step;
    logic         facing, facing_n, facing_step;
    logic         detect, detect_n;
    logic [7:0]   anim_div, anim_n;
    logic [1:0]   walk_frame, frame_n;
    logic [7:0]   death_cnt, death_n;
    logic         tick;

    // Widened to 12 bits so sums such as char_pos+char_w+VIEW_DIST cannot wrap.
    logic [11:0] x12, xw12, cp12, cpe12, dx12, dy12;
    logic        seen, hit_now, visible, in_box;
    logic [9:0]  col, row;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign x12   = {2'b00, x};
    assign xw12  = x12 + {2'b00, W};
    assign cp12  = {2'b00, bus.char_pos};
    assign cpe12 = cp12 + {2'b00, bus.char_w};
    assign dx12  = {2'b00, bus.DrawX};
    assign dy12  = {2'b00, bus.DrawY};

    // Tick decisions: view cone, body overlap and the bounded patrol step.
    always_comb begin
        x_step      = x;
        facing_step = facing;
        if (facing == FACE_RIGHT)
            seen = (cp12 >= xw12) && (cp12 <= xw12 + {2'b00, VIEW_DIST});
        else
            seen = (cpe12 <= x12) && (x12 <= cpe12 + {2'b00, VIEW_DIST});
        seen    = seen && !bus.camo;
        hit_now = bus.hit && (cp12 < xw12) && (x12 < cpe12);
        if (facing == FACE_RIGHT) begin
            if (x12 + {2'b00, SPEED} >= {2'b00, X_MAX}) begin
                x_step      = X_MAX;
                facing_step = FACE_LEFT;
            end else begin
                x_step = x + SPEED;
            end
        end else begin
            if (x12 <= {2'b00, X_MIN} + {2'b00, SPEED}) begin
                x_step      = X_MIN;
                facing_step = FACE_RIGHT;
            end else begin
                x_step = x - SPEED;
            end
        end
    end

    // Next-state logic: spawn wins over the tick; on a tick hit beats
    // detection beats movement, one transition at most.
    always_comb begin
        state_n  = state;
        x_n      = x;
        facing_n = facing;
        detect_n = detect;
        anim_n   = anim_div;
        frame_n  = walk_frame;
        death_n  = death_cnt;
        if (bus.spawn && (state == ST_IDLE || state == ST_DEAD)) begin
            state_n  = ST_PATROL;
            x_n      = X_START;
            facing_n = FACE_RIGHT;
            detect_n = 1'b0;
            anim_n   = '0;
            frame_n  = '0;
            death_n  = '0;
        end else if (tick) begin
            case (state)
                ST_PATROL: begin
                    if (hit_now) begin
                        state_n = ST_DYING;
                        death_n = DEATH_LOAD;
                    end else if (seen) begin
                        state_n  = ST_ALERT;
                        detect_n = 1'b1;
                    end else begin
                        x_n      = x_step;
                        facing_n = facing_step;
                        if (anim_div == ANIM_LAST) begin
                            anim_n  = '0;
                            frame_n = (walk_frame == FRAME_LAST) ? 2'd0 : walk_frame + 2'd1;
                        end else begin
                            anim_n = anim_div + 8'd1;
                        end
                    end
                end
                ST_ALERT: begin
                    if (hit_now) begin
                        state_n = ST_DYING;
                        death_n = DEATH_LOAD;
                    end else begin
                        facing_n = (bus.char_pos > x);
                    end
                end
                ST_DYING: begin
                    if (death_cnt == 8'd0) state_n = ST_DEAD;
                    else                   death_n = death_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            x          <= X_START;
            facing     <= FACE_RIGHT;
            detect     <= 1'b0;
            anim_div   <= '0;
            walk_frame <= '0;
            death_cnt  <= '0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            facing     <= facing_n;
            detect     <= detect_n;
            anim_div   <= anim_n;
            walk_frame <= frame_n;
            death_cnt  <= death_n;
        end
    end

    // Pixel coverage and ROM address, combinational from registered state.
    always_comb begin
        col     = bus.DrawX - x;
        row     = bus.DrawY - Y_TOP;
        visible = (state == ST_PATROL) || (state == ST_ALERT) ||
                  ((state == ST_DYING) && !death_cnt[2]);
        in_box  = (dx12 >= x12) && (dx12 < xw12) &&
                  (dy12 >= {2'b00, Y_TOP}) && (dy12 < {2'b00, Y_TOP} + {2'b00, H});
    end

    assign bus.is_enemy    = in_box && visible;
    assign bus.enemy_addr  = ADDR_W'(sprite_addr({16'd0, ROM_BASE}, {30'd0, walk_frame},
                                                 {22'd0, W}, {22'd0, H}, {22'd0, row},
                                                 {22'd0, col}, facing));
    assign bus.enemy_alive = (state == ST_PATROL) || (state == ST_ALERT);
    assign bus.detect      = detect;
    assign bus.facing      = facing;
    assign bus.state       = state;
    assign bus.pos_x       = x;

endmodule

// File: tb/tb_enemy_patrol.sv
// Bench for enemy_patrol: three instances (defaults, fast spawn near the right
// bound, spawn at x=400) checked against a tick-level behavioural model.
module tb_enemy_patrol;
    import enemy_pkg::*;

    localparam int W = 60, H = 54, YT = 358, XMIN = 350, XMAX = 580, VD = 200;
    localparam int BASE = 34372, DT = 30, AD = 8, NW = 2;

    logic Clk = 1'b0, Reset = 1'b1;
    always #10 Clk = ~Clk;

    int checks = 0, errors = 0;

    logic       fc_v[3], spawn_v[3], hit_v[3], camo_v[3];
    logic [9:0] cp_v[3], cw_v[3], dx_v[3], dy_v[3];
    enemy_state_t st_o[3];
    logic [9:0]   px_o[3];
    logic         face_o[3], det_o[3], alive_o[3], ise_o[3];
    logic [15:0]  addr_o[3];

    enemy_patrol_if #(.ADDR_W(16)) ifa ();
    enemy_patrol_if #(.ADDR_W(16)) ifb ();
    enemy_patrol_if #(.ADDR_W(16)) ifc ();

    enemy_patrol u_a (.Clk(Clk), .Reset(Reset), .frame_clk(fc_v[0]), .bus(ifa.slave));
    enemy_patrol #(.X_START(10'd579), .SPEED(10'd3))
        u_b (.Clk(Clk), .Reset(Reset), .frame_clk(fc_v[1]), .bus(ifb.slave));
    enemy_patrol #(.X_START(10'd400))
        u_c (.Clk(Clk), .Reset(Reset), .frame_clk(fc_v[2]), .bus(ifc.slave));

    assign ifa.DrawX = dx_v[0]; assign ifb.DrawX = dx_v[1]; assign ifc.DrawX = dx_v[2];
    assign ifa.DrawY = dy_v[0]; assign ifb.DrawY = dy_v[1]; assign ifc.DrawY = dy_v[2];
    assign ifa.spawn = spawn_v[0]; assign ifb.spawn = spawn_v[1]; assign ifc.spawn = spawn_v[2];
    assign ifa.char_pos = cp_v[0]; assign ifb.char_pos = cp_v[1]; assign ifc.char_pos = cp_v[2];
    assign ifa.char_w = cw_v[0]; assign ifb.char_w = cw_v[1]; assign ifc.char_w = cw_v[2];
    assign ifa.hit = hit_v[0]; assign ifb.hit = hit_v[1]; assign ifc.hit = hit_v[2];
    assign ifa.camo = camo_v[0]; assign ifb.camo = camo_v[1]; assign ifc.camo = camo_v[2];
    assign st_o[0] = ifa.state; assign st_o[1] = ifb.state; assign st_o[2] = ifc.state;
    assign px_o[0] = ifa.pos_x; assign px_o[1] = ifb.pos_x; assign px_o[2] = ifc.pos_x;
    assign face_o[0] = ifa.facing; assign face_o[1] = ifb.facing; assign face_o[2] = ifc.facing;
    assign det_o[0] = ifa.detect; assign det_o[1] = ifb.detect; assign det_o[2] = ifc.detect;
    assign alive_o[0] = ifa.enemy_alive; assign alive_o[1] = ifb.enemy_alive; assign alive_o[2] = ifc.enemy_alive;
    assign ise_o[0] = ifa.is_enemy; assign ise_o[1] = ifb.is_enemy; assign ise_o[2] = ifc.is_enemy;
    assign addr_o[0] = ifa.enemy_addr; assign addr_o[1] = ifb.enemy_addr; assign addr_o[2] = ifc.enemy_addr;

    // Reference model, one entry per instance, in plain integers.
    int p_start[3] = '{520, 579, 400};
    int p_speed[3] = '{1, 3, 1};
    enemy_state_t m_st[3];
    int m_x[3], m_f[3], m_det[3], m_wf[3], m_adiv[3], m_d[3];

    task automatic model_reset_all();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = ST_IDLE; m_x[i] = p_start[i]; m_f[i] = 1; m_det[i] = 0;
            m_wf[i] = 0; m_adiv[i] = 0; m_d[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit sp, input bit tk);
        int cp, cw, gap, target;
        bit seen;
        cp = int'(cp_v[i]);
        cw = int'(cw_v[i]);
        if (sp && (m_st[i] == ST_IDLE || m_st[i] == ST_DEAD)) begin
            m_st[i] = ST_PATROL; m_x[i] = p_start[i]; m_f[i] = 1; m_det[i] = 0;
            m_wf[i] = 0; m_adiv[i] = 0; m_d[i] = 0;
        end else if (tk) begin
            if ((m_st[i] == ST_PATROL || m_st[i] == ST_ALERT) && hit_v[i] &&
                cp < m_x[i] + W && m_x[i] < cp + cw) begin
                m_st[i] = ST_DYING; m_d[i] = DT - 1;
            end else if (m_st[i] == ST_PATROL) begin
                gap  = (m_f[i] == 1) ? cp - (m_x[i] + W) : m_x[i] - (cp + cw);
                seen = !camo_v[i] && gap >= 0 && gap <= VD;
                if (seen) begin
                    m_st[i] = ST_ALERT; m_det[i] = 1;
                end else begin
                    target = (m_f[i] == 1) ? m_x[i] + p_speed[i] : m_x[i] - p_speed[i];
                    if (m_f[i] == 1 && target >= XMAX) begin m_x[i] = XMAX; m_f[i] = 0; end
                    else if (m_f[i] == 0 && target <= XMIN) begin m_x[i] = XMIN; m_f[i] = 1; end
                    else m_x[i] = target;
                    m_adiv[i]++;
                    if (m_adiv[i] == AD) begin m_adiv[i] = 0; m_wf[i] = (m_wf[i] + 1) % NW; end
                end
            end else if (m_st[i] == ST_ALERT) begin
                m_f[i] = (cp > m_x[i]) ? 1 : 0;
            end else if (m_st[i] == ST_DYING) begin
                if (m_d[i] == 0) m_st[i] = ST_DEAD;
                else m_d[i]--;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Probe a pixel and compare coverage/address against the model.
    task automatic probe(input int i, input int dx, input int dy);
        bit vis, exp_in;
        int col, off;
        dx_v[i] = 10'(dx);
        dy_v[i] = 10'(dy);
        #1;
        vis = (m_st[i] == ST_PATROL) || (m_st[i] == ST_ALERT) ||
              (m_st[i] == ST_DYING && ((m_d[i] >> 2) & 1) == 0);
        exp_in = vis && dx >= m_x[i] && dx < m_x[i] + W && dy >= YT && dy < YT + H;
        chk($sformatf("is_enemy%0d(%0d,%0d)", i, dx, dy), 32'(ise_o[i]), 32'(exp_in));
        if (exp_in) begin
            col = dx - m_x[i];
            off = (m_f[i] == 1) ? col : W - 1 - col;
            chk($sformatf("addr%0d(%0d,%0d)", i, dx, dy), 32'(addr_o[i]),
                32'((BASE + m_wf[i] * W * H + (dy - YT) * W + off) % 65536));
        end
    endtask

    task automatic check_all(input int i);
        chk($sformatf("state%0d", i), 32'(st_o[i]), 32'(m_st[i]));
        chk($sformatf("x%0d", i), 32'(px_o[i]), 32'(m_x[i]));
        chk($sformatf("facing%0d", i), 32'(face_o[i]), 32'(m_f[i]));
        chk($sformatf("detect%0d", i), 32'(det_o[i]), 32'(m_det[i]));
        chk($sformatf("alive%0d", i), 32'(alive_o[i]),
            32'(m_st[i] == ST_PATROL || m_st[i] == ST_ALERT));
        probe(i, m_x[i] + $urandom_range(0, W + 9) - 5, YT + $urandom_range(0, H + 9) - 5);
    endtask

    // One frame strobe; the tick is live in the cycle after the third edge,
    // which is where a concurrent spawn or reset is placed.
    task automatic do_tick(input int i, input bit with_spawn, input bit with_reset);
        @(negedge Clk); fc_v[i] = 1'b1;
        repeat (3) @(negedge Clk);
        if (with_spawn) spawn_v[i] = 1'b1;
        if (with_reset) Reset = 1'b1;
        @(negedge Clk);
        if (with_reset) model_reset_all();
        else model_step(i, with_spawn, 1'b1);
        spawn_v[i] = 1'b0; Reset = 1'b0; fc_v[i] = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_spawn(input int i);
        @(negedge Clk); spawn_v[i] = 1'b1;
        @(negedge Clk); spawn_v[i] = 1'b0;
        model_step(i, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clk); Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset_all();
    endtask

    task automatic set_player(input int i, input int cp, input int cw, input bit h, input bit c);
        cp_v[i] = 10'(cp); cw_v[i] = 10'(cw); hit_v[i] = h; camo_v[i] = c;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            fc_v[i] = 1'b0; spawn_v[i] = 1'b0; dx_v[i] = '0; dy_v[i] = '0;
            set_player(i, 0, 0, 1'b0, 1'b0);
        end
        model_reset_all();
        do_reset();

        // Reset values on every instance.
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_alive%0d", i), 32'(alive_o[i]), 32'd0);
            chk($sformatf("rst_detect%0d", i), 32'(det_o[i]), 32'd0);
            chk($sformatf("rst_facing%0d", i), 32'(face_o[i]), 32'd1);
            probe(i, p_start[i] + 1, 360);
            check_all(i);
        end

        // Defaults: spawn then 10 ticks walking right.
        do_spawn(0); check_all(0);
        for (int t = 0; t < 10; t++) begin do_tick(0, 1'b0, 1'b0); check_all(0); end
        chk("a_x_after10", 32'(px_o[0]), 32'd530);
        chk("a_facing_after10", 32'(face_o[0]), 32'd1);
        chk("a_alive_after10", 32'(alive_o[0]), 32'd1);
        dx_v[0] = 10'd531; dy_v[0] = 10'd360; #1;
        chk("a_is_enemy_531_360", 32'(ise_o[0]), 32'd1);

        // Right bound clamp with SPEED=3.
        do_spawn(1);
        do_tick(1, 1'b0, 1'b0); check_all(1);
        chk("b_x_clamp", 32'(px_o[1]), 32'd580);
        chk("b_facing_clamp", 32'(face_o[1]), 32'd0);
        do_tick(1, 1'b0, 1'b0); check_all(1);
        chk("b_x_back", 32'(px_o[1]), 32'd577);

        // Detection at x=400 facing right, then the same with camo.
        set_player(2, 600, 40, 1'b0, 1'b0);
        do_spawn(2); do_tick(2, 1'b0, 1'b0); check_all(2);
        chk("c_alert_state", 32'(st_o[2]), 32'(ST_ALERT));
        chk("c_alert_detect", 32'(det_o[2]), 32'd1);
        do_reset();
        set_player(2, 600, 40, 1'b0, 1'b1);
        do_spawn(2); do_tick(2, 1'b0, 1'b0); check_all(2);
        chk("c_camo_state", 32'(st_o[2]), 32'(ST_PATROL));
        chk("c_camo_detect", 32'(det_o[2]), 32'd0);

        // Hit, 30 ticks of dying, dead, respawn.
        do_reset();
        do_spawn(2);
        set_player(2, 420, 54, 1'b1, 1'b0);
        do_tick(2, 1'b0, 1'b0); check_all(2);
        chk("c_dying", 32'(st_o[2]), 32'(ST_DYING));
        set_player(2, 0, 0, 1'b0, 1'b0);
        for (int t = 0; t < DT - 1; t++) begin do_tick(2, 1'b0, 1'b0); check_all(2); end
        chk("c_still_dying", 32'(st_o[2]), 32'(ST_DYING));
        do_tick(2, 1'b0, 1'b0); check_all(2);
        chk("c_dead", 32'(st_o[2]), 32'(ST_DEAD));
        chk("c_dead_alive", 32'(alive_o[2]), 32'd0);
        dx_v[2] = 10'd420; dy_v[2] = 10'd360; #1;
        chk("c_dead_is_enemy", 32'(ise_o[2]), 32'd0);
        do_spawn(2); check_all(2);
        chk("c_respawn_state", 32'(st_o[2]), 32'(ST_PATROL));
        chk("c_respawn_detect", 32'(det_o[2]), 32'd0);

        // Full out-and-back walk: 360 ticks returns to x=400 facing left, frame 1.
        for (int t = 0; t < 360; t++) begin do_tick(2, 1'b0, 1'b0); check_all(2); end
        set_player(2, 300, 50, 1'b0, 1'b0);
        do_tick(2, 1'b0, 1'b0); check_all(2);
        dx_v[2] = 10'd400; dy_v[2] = 10'd358; #1;
        chk("c_addr_left", 32'(addr_o[2]), 32'd37671);
        chk("c_addr_left_cov", 32'(ise_o[2]), 32'd1);
        set_player(2, 500, 50, 1'b0, 1'b0);
        do_tick(2, 1'b0, 1'b0); check_all(2);
        dx_v[2] = 10'd400; dy_v[2] = 10'd358; #1;
        chk("c_addr_right", 32'(addr_o[2]), 32'd37612);

        // Randomised play on the default instance.
        for (int t = 0; t < 250; t++) begin
            set_player(0, $urandom_range(0, 800), $urandom_range(1, 120),
                       ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
            do_tick(0, ($urandom_range(0, 9) == 0), 1'b0);
            check_all(0);
            if ($urandom_range(0, 19) == 0) begin do_spawn(0); check_all(0); end
        end

        // Reset mid-DYING together with spawn and a tick.
        do_reset();
        set_player(0, 0, 0, 1'b0, 1'b0);
        do_spawn(0);
        set_player(0, 530, 20, 1'b1, 1'b0);
        do_tick(0, 1'b0, 1'b0); check_all(0);
        chk("a_dying", 32'(st_o[0]), 32'(ST_DYING));
        set_player(0, 0, 0, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin do_tick(0, 1'b0, 1'b0); check_all(0); end
        do_tick(0, 1'b1, 1'b1);
        chk("rst_dying_state", 32'(st_o[0]), 32'(ST_IDLE));
        chk("rst_dying_x", 32'(px_o[0]), 32'd520);
        chk("rst_dying_facing", 32'(face_o[0]), 32'd1);
        chk("rst_dying_detect", 32'(det_o[0]), 32'd0);
        chk("rst_dying_alive", 32'(alive_o[0]), 32'd0);
        dx_v[0] = 10'd525; dy_v[0] = 10'd360; #1;
        chk("rst_dying_is_enemy", 32'(ise_o[0]), 32'd0);
        for (int i = 0; i < 3; i++) check_all(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
